// File: rtl/ext_int_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register map,
// controller state encoding and the width of the ID+1 claim code.
package ExtInt_Pkg;
  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_TRIGGER = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  localparam int CODE_W     = 6;   // ID+1 for up to 32 sources, 0 = none
  localparam int INT_CODE_W = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_e;
endpackage

// File: rtl/ext_int_ctrl_gateway.sv
// Per-source gateway: edge/level detection on the sampled line, sticky
// pending bit, and the open/closed gate that blocks a claimed source.
module ExtIntGateway (
  input  logic clk,
  input  logic rst_sync,
  input  logic i_smp,
  input  logic i_edge_mode,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pend,
  output logic o_open
);
  logic r_hist, r_pend, r_open;
  logic w_set;

  assign w_set = r_open & (i_edge_mode ? (i_smp & ~r_hist) : i_smp);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_hist <= 1'b0;
      r_pend <= 1'b0;
      r_open <= 1'b1;
    end else begin
      r_hist <= i_smp;
      // the claim of this source beats a same-cycle set of this source
      if (i_claim)      r_pend <= 1'b0;
      else if (w_set)   r_pend <= 1'b1;
      if (i_claim)      r_open <= 1'b0;
      else if (i_complete) r_open <= 1'b1;
    end
  end

  assign o_pend = r_pend;
  assign o_open = r_open;
endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: fixed-priority (lowest ID) claim/complete
// with one source in service. Define EXT_INT_SYNC_EN for a 2-flop input sync.
module ext_int_ctrl
  import ExtInt_Pkg::*;
#(
  parameter int SRC_NUM = 16
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic [SRC_NUM-1:0]    irq_src,
  input  logic                  bus_wr_en,
  input  logic                  bus_rd_en,
  input  logic [1:0]            bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  meip,
  output logic [INT_CODE_W-1:0] custom_int_code
);
  logic [SRC_NUM-1:0]    r_enable, r_trigger, r_smp;
  logic [SRC_NUM-1:0]    w_pend, w_open, w_elig, w_claim, w_complete;
  logic [CODE_W-1:0]     r_svc_code, w_win_idx, w_win_code;
  logic [INT_CODE_W-1:0] r_code;
  logic [31:0]           r_rdata, w_rdata;
  logic                  w_any, w_claim_ok, w_complete_ok;
  logic                  w_unused;
  state_e                r_state, w_state_nxt;

  assign w_unused = &{1'b0, bus_wdata};

`ifdef EXT_INT_SYNC_EN
  logic [SRC_NUM-1:0] r_meta;
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_meta <= '0;
      r_smp  <= '0;
    end else begin
      r_meta <= irq_src;
      r_smp  <= r_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst_sync) r_smp <= '0;
    else          r_smp <= irq_src;
  end
`endif

  assign w_elig = w_pend & r_enable & w_open;

  // descending scan so the lowest eligible ID is the last one written
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    for (int i = SRC_NUM-1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any     = 1'b1;
        w_win_idx = CODE_W'(i);
      end
    end
  end
  assign w_win_code = w_any ? (w_win_idx + CODE_W'(1)) : '0;

  assign w_claim_ok    = bus_rd_en && (bus_addr == REG_CLAIM) && (r_state == ST_REQ) && w_any;
  assign w_complete_ok = bus_wr_en && (bus_addr == REG_CLAIM) && (r_state == ST_SERVICE) &&
                         (bus_wdata[CODE_W-1:0] == r_svc_code);

  for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_gw
    assign w_claim[gi]    = w_claim_ok && (w_win_idx == CODE_W'(gi));
    assign w_complete[gi] = w_complete_ok && (r_svc_code == CODE_W'(gi + 1));
    ExtIntGateway u_gw (
      .clk         (clk),
      .rst_sync    (rst_sync),
      .i_smp       (r_smp[gi]),
      .i_edge_mode (r_trigger[gi]),
      .i_claim     (w_claim[gi]),
      .i_complete  (w_complete[gi]),
      .o_pend      (w_pend[gi]),
      .o_open      (w_open[gi])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_state_nxt = ST_REQ;
      ST_REQ:     if (w_claim_ok) w_state_nxt = ST_SERVICE;
                  else if (!w_any) w_state_nxt = ST_IDLE;
      ST_SERVICE: if (w_complete_ok) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (bus_addr)
      REG_ENABLE:  w_rdata = 32'(r_enable);
      REG_PENDING: w_rdata = 32'(w_pend);
      REG_TRIGGER: w_rdata = 32'(r_trigger);
      REG_CLAIM:   w_rdata = w_claim_ok ? 32'(w_win_code) : '0;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_state    <= ST_IDLE;
      r_enable   <= '0;
      r_trigger  <= '0;
      r_svc_code <= '0;
      r_code     <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= INT_CODE_W'(w_win_code);
      if (bus_wr_en && bus_addr == REG_ENABLE)  r_enable  <= bus_wdata[SRC_NUM-1:0];
      if (bus_wr_en && bus_addr == REG_TRIGGER) r_trigger <= bus_wdata[SRC_NUM-1:0];
      if (w_claim_ok) r_svc_code <= w_win_code;
      if (bus_rd_en)  r_rdata    <= w_rdata;
    end
  end

  assign meip            = (r_state == ST_REQ);
  assign custom_int_code = r_code;
  assign bus_rdata       = r_rdata;
endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: claim/complete flow, priority, gateway
// blocking, masking, reset in service and source-to-meip latency.
module tb_ext_int_ctrl;
  localparam int SRC_NUM = 16;
`ifdef EXT_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_sync;
  logic [SRC_NUM-1:0] irq_src;
  logic               bus_wr_en, bus_rd_en;
  logic [1:0]         bus_addr;
  logic [31:0]        bus_wdata, bus_rdata;
  logic               meip;
  logic [26:0]        custom_int_code;
  int                 n_chk = 0;
  int                 n_fail = 0;

  ext_int_ctrl #(.SRC_NUM(SRC_NUM)) dut (
    .clk             (clk),
    .rst_sync        (rst_sync),
    .irq_src         (irq_src),
    .bus_wr_en       (bus_wr_en),
    .bus_rd_en       (bus_rd_en),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .meip            (meip),
    .custom_int_code (custom_int_code)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_wr_en = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_rd_en = 1'b1; bus_addr = a;
    @(posedge clk); #1;
    d = bus_rdata;
    bus_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_sync = 1'b1; irq_src = '0; bus_wr_en = 1'b0; bus_rd_en = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    tick(2);
    rst_sync = 1'b0;
  endtask

  task automatic pulse(input int s);
    @(negedge clk); irq_src[s] = 1'b1;
    @(negedge clk); irq_src[s] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL reset_meip: got %0d exp 0", meip); end
    n_chk++; if (custom_int_code !== 27'd0) begin n_fail++; $display("FAIL reset_code: got %0d exp 0", custom_int_code); end
    n_chk++; if (bus_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %0h exp 0", bus_rdata); end
    rd(2'd0, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_enable: got %0h exp 0", d); end
    rd(2'd2, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_trigger: got %0h exp 0", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d);
    n_chk++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL mask_enable: got %0h exp 0000ffff", d); end
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, d);
    n_chk++; if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL mask_trigger: got %0h exp 0000ffff", d); end
    tick(3);
    n_chk++; if (bus_rdata !== 32'h0000_FFFF) begin n_fail++; $display("FAIL rdata_hold: got %0h exp 0000ffff", bus_rdata); end
    rd(2'd1, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL mask_pending: got %0h exp 0", d); end
  endtask

  task automatic test_edge_claim();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h4); wr(2'd2, 32'h4);
    pulse(2);
    tick(5);
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL edge_meip: got %0d exp 1", meip); end
    n_chk++; if (custom_int_code !== 27'd3) begin n_fail++; $display("FAIL edge_code: got %0d exp 3", custom_int_code); end
    rd(2'd3, d);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL edge_claim: got %0d exp 3", d); end
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL edge_meip_svc: got %0d exp 0", meip); end
    tick(2);
    n_chk++; if (custom_int_code !== 27'd0) begin n_fail++; $display("FAIL edge_code_svc: got %0d exp 0", custom_int_code); end
    rd(2'd1, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL edge_pend_clr: got %0h exp 0", d); end
  endtask

  task automatic test_level_priority();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h22);
    @(negedge clk); irq_src[1] = 1'b1; irq_src[5] = 1'b1;
    tick(4);
    n_chk++; if (custom_int_code !== 27'd2) begin n_fail++; $display("FAIL lvl_code: got %0d exp 2", custom_int_code); end
    rd(2'd3, d);
    n_chk++; if (d !== 32'd2) begin n_fail++; $display("FAIL lvl_claim: got %0d exp 2", d); end
    tick(2);
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL lvl_meip_svc: got %0d exp 0", meip); end
    n_chk++; if (custom_int_code !== 27'd6) begin n_fail++; $display("FAIL lvl_code_svc: got %0d exp 6", custom_int_code); end
    wr(2'd3, 32'd2);
    tick(3);
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL lvl_reassert: got %0d exp 1", meip); end
    n_chk++; if (custom_int_code !== 27'd2) begin n_fail++; $display("FAIL lvl_recode: got %0d exp 2", custom_int_code); end
    irq_src = '0;
  endtask

  task automatic test_gateway_block();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h8); wr(2'd2, 32'h8);
    pulse(3);
    tick(5);
    rd(2'd3, d);
    n_chk++; if (d !== 32'd4) begin n_fail++; $display("FAIL gw_claim: got %0d exp 4", d); end
    pulse(3);
    tick(5);
    rd(2'd1, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL gw_pend_blocked: got %0h exp 0", d); end
    wr(2'd3, 32'd4);
    tick(3);
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL gw_idle_meip: got %0d exp 0", meip); end
    rd(2'd3, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL gw_idle_claim: got %0d exp 0", d); end
  endtask

  task automatic test_bad_complete();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h28);
    @(negedge clk); irq_src[3] = 1'b1; irq_src[5] = 1'b1;
    tick(4);
    rd(2'd3, d);
    n_chk++; if (d !== 32'd4) begin n_fail++; $display("FAIL bad_claim: got %0d exp 4", d); end
    irq_src[3] = 1'b0;
    wr(2'd3, 32'd7);
    tick(3);
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL bad_meip: got %0d exp 0", meip); end
    rd(2'd3, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL bad_claim_svc: got %0d exp 0", d); end
    wr(2'd3, 32'd4);
    tick(3);
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL good_meip: got %0d exp 1", meip); end
    n_chk++; if (custom_int_code !== 27'd6) begin n_fail++; $display("FAIL good_code: got %0d exp 6", custom_int_code); end
    irq_src = '0;
  endtask

  task automatic test_set_vs_claim();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h50); wr(2'd2, 32'h40);
    @(negedge clk); irq_src[4] = 1'b1;
    tick(4);
    n_chk++; if (custom_int_code !== 27'd5) begin n_fail++; $display("FAIL svc_code5: got %0d exp 5", custom_int_code); end
    // edge on source 6 lands in the same cycle as the claim of source 4
    @(negedge clk); irq_src[6] = 1'b1;
`ifdef EXT_INT_SYNC_EN
    tick(1);
`endif
    rd(2'd3, d);
    n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL svc_claim: got %0d exp 5", d); end
    rd(2'd1, d);
    n_chk++; if (d !== 32'h40) begin n_fail++; $display("FAIL svc_pend: got %0h exp 40", d); end
    n_chk++; if (custom_int_code !== 27'd7) begin n_fail++; $display("FAIL svc_code7: got %0d exp 7", custom_int_code); end
    irq_src = '0;
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    do_reset();
    wr(2'd2, 32'h1);
    pulse(0);
    tick(5);
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL dis_meip: got %0d exp 0", meip); end
    rd(2'd1, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL dis_pend: got %0h exp 1", d); end
    wr(2'd0, 32'h1);
    tick(2);
    n_chk++; if (meip !== 1'b1) begin n_fail++; $display("FAIL en_meip: got %0d exp 1", meip); end
    n_chk++; if (custom_int_code !== 27'd1) begin n_fail++; $display("FAIL en_code: got %0d exp 1", custom_int_code); end
  endtask

  task automatic test_reset_in_service();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h84); wr(2'd2, 32'h4);
    @(negedge clk); irq_src[7] = 1'b1;
    pulse(2);
    tick(5);
    rd(2'd3, d);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL rsv_claim: got %0d exp 3", d); end
    tick(2);
    n_chk++; if (custom_int_code !== 27'd8) begin n_fail++; $display("FAIL rsv_code: got %0d exp 8", custom_int_code); end
    @(negedge clk);
    rst_sync = 1'b1; bus_rd_en = 1'b1; bus_addr = 2'd0;
    @(negedge clk);
    rst_sync = 1'b0; bus_rd_en = 1'b0; irq_src = '0;
    n_chk++; if (meip !== 1'b0) begin n_fail++; $display("FAIL rsv_meip: got %0d exp 0", meip); end
    n_chk++; if (custom_int_code !== 27'd0) begin n_fail++; $display("FAIL rsv_code0: got %0d exp 0", custom_int_code); end
    n_chk++; if (bus_rdata !== 32'd0) begin n_fail++; $display("FAIL rsv_rdata: got %0h exp 0", bus_rdata); end
    rd(2'd0, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL rsv_enable: got %0h exp 0", d); end
    rd(2'd1, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL rsv_pend: got %0h exp 0", d); end
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    wr(2'd0, 32'h1); wr(2'd2, 32'h1);
    @(negedge clk); irq_src[0] = 1'b1;
    @(posedge clk);  // sampling edge
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (meip) lat = k;
    end
    n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL latency: got %0d exp %0d", lat, LAT); end
    @(negedge clk); irq_src[0] = 1'b0;
  endtask

  initial begin
    rst_sync = 1'b1; irq_src = '0; bus_wr_en = 1'b0; bus_rd_en = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    test_reset();
    test_mask();
    test_edge_claim();
    test_level_priority();
    test_gateway_block();
    test_bad_complete();
    test_set_vs_claim();
    test_disabled();
    test_reset_in_service();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
